// File: rtl/gmii_rx_framer_param_if.sv
// ---------------------------------------------------------------------------
// gmii_rx_framer_param_if
//   Bundles the GMII receive inputs, the downstream FIFO fill level and all
//   framer outputs (packet words, per-frame flag, event pulses, statistics).
//   master : the GMII/FIFO side that drives rx bytes and observes the outputs
//   slave  : the framer itself
// ---------------------------------------------------------------------------
interface gmii_rx_framer_param_if #(
  parameter int WORD_BYTES = 16,
  parameter int USEDW_W    = 8,
  parameter int CNT_W      = 32
);
  localparam int OW = 8 * WORD_BYTES + 11;

  logic [7:0]         gmii_rxd;
  logic               gmii_rxdv;
  logic               gmii_rxer;
  logic [USEDW_W-1:0] pkt_usedw;

  logic               crc_data_valid;
  logic [OW-1:0]      crc_data;
  logic               pkt_valid_wrreq;
  logic               pkt_valid;
  logic               port_receive;
  logic               port_discard;
  logic               port_pream;
  logic [CNT_W-1:0]   stat_good;
  logic [CNT_W-1:0]   stat_bad;
  logic [CNT_W-1:0]   stat_drop;

  modport master (
    output gmii_rxd, gmii_rxdv, gmii_rxer, pkt_usedw,
    input  crc_data_valid, crc_data, pkt_valid_wrreq, pkt_valid,
    input  port_receive, port_discard, port_pream,
    input  stat_good, stat_bad, stat_drop
  );

  modport slave (
    input  gmii_rxd, gmii_rxdv, gmii_rxer, pkt_usedw,
    output crc_data_valid, crc_data, pkt_valid_wrreq, pkt_valid,
    output port_receive, port_discard, port_pream,
    output stat_good, stat_bad, stat_drop
  );
endinterface

// File: rtl/gmii_rx_framer_param.sv
// ---------------------------------------------------------------------------
// gmii_rx_framer_param
//   GMII receive framer. Strips preamble/SFD, packs payload bytes MSB-first
//   into WORD_BYTES-wide packet words with an 11-bit header
//   {sof, eof, 1, valid_bytes-1[3:0], 4'b0}, and writes one good/bad flag per
//   written frame. Frames arriving while the data FIFO is nearly full are
//   dropped at the SFD. Frames longer than MAX_LEN are truncated and flagged
//   bad. Saturating good/bad/drop statistics.
// Ports
//   clk    : GMII rx clock
//   reset  : asynchronous, active-low
//   bus    : slave modport of gmii_rx_framer_param_if
//            in : gmii_rxd, gmii_rxdv, gmii_rxer, pkt_usedw
//            out: crc_data_valid, crc_data, pkt_valid_wrreq, pkt_valid,
//                 port_receive, port_discard, port_pream,
//                 stat_good, stat_bad, stat_drop
// ---------------------------------------------------------------------------
module gmii_rx_framer_param #(
  parameter int WORD_BYTES = 16,
  parameter int USEDW_W    = 8,
  parameter int AFULL_TH   = 160,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  gmii_rx_framer_param_if.slave  bus
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int OW    = DW + 11;
  localparam int CW    = $clog2(WORD_BYTES + 1);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0]    FULL    = CW'(WORD_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     acc_q;
  logic [DW-1:0]     acc_d;
  logic [CW-1:0]     cnt_q;        // bytes held in acc_q
  logic [LEN_W-1:0]  len_q;        // bytes accepted into the frame so far
  logic              sof_q;
  logic              bad_q;
  logic              flag_pend_q;  // eof word went out this cycle, flag follows
  logic              flag_good_q;

  logic              crc_data_valid_q;
  logic [OW-1:0]     crc_data_q;
  logic              pkt_valid_wrreq_q;
  logic              pkt_valid_q;
  logic              port_receive_q;
  logic              port_discard_q;
  logic              port_pream_q;
  logic [CNT_W-1:0]  stat_good_q;
  logic [CNT_W-1:0]  stat_bad_q;
  logic [CNT_W-1:0]  stat_drop_q;

  logic              fifo_busy;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic len_ok(input logic [LEN_W-1:0] l);
    return (l >= LEN_MIN) && (l <= LEN_MAX);
  endfunction

  function automatic logic [OW-1:0] mk_word(input logic sof, input logic eof,
                                            input logic [CW-1:0] n,
                                            input logic [DW-1:0] d);
    logic [3:0] vf;
    vf = 4'(n - CW'(1));
    return {sof, eof, 1'b1, vf, 4'b0000, d};
  endfunction

  assign fifo_busy = (32'(bus.pkt_usedw) >= 32'(AFULL_TH));

  // Current byte dropped into the next free slot; slot 0 is the top byte.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (cnt_q == CW'(i)) acc_d[DW-8-8*i +: 8] = bus.gmii_rxd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      acc_q             <= '0;
      cnt_q             <= '0;
      len_q             <= '0;
      sof_q             <= 1'b0;
      bad_q             <= 1'b0;
      flag_pend_q       <= 1'b0;
      flag_good_q       <= 1'b0;
      crc_data_valid_q  <= 1'b0;
      crc_data_q        <= '0;
      pkt_valid_wrreq_q <= 1'b0;
      pkt_valid_q       <= 1'b0;
      port_receive_q    <= 1'b0;
      port_discard_q    <= 1'b0;
      port_pream_q      <= 1'b0;
      stat_good_q       <= '0;
      stat_bad_q        <= '0;
      stat_drop_q       <= '0;
    end else begin
      crc_data_valid_q  <= 1'b0;
      pkt_valid_wrreq_q <= 1'b0;
      pkt_valid_q       <= 1'b0;
      port_receive_q    <= 1'b0;
      port_discard_q    <= 1'b0;
      port_pream_q      <= 1'b0;
      flag_pend_q       <= 1'b0;

      // Flag write runs independently of the FSM so a back-to-back frame
      // (one idle cycle) can already be in its preamble.
      if (flag_pend_q) begin
        pkt_valid_wrreq_q <= 1'b1;
        pkt_valid_q       <= flag_good_q;
        if (flag_good_q) begin
          port_receive_q <= 1'b1;
          stat_good_q    <= sat_inc(stat_good_q);
        end else begin
          stat_bad_q     <= sat_inc(stat_bad_q);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.gmii_rxdv) begin
            if (bus.gmii_rxd == 8'h55) begin
              state_q <= S_PRE;
            end else begin
              state_q      <= S_DROP;
              port_pream_q <= 1'b1;
            end
          end
        end

        S_PRE: begin
          if (!bus.gmii_rxdv) begin
            state_q <= S_IDLE;
          end else if (bus.gmii_rxd == 8'hD5) begin
            if (fifo_busy) begin
              state_q        <= S_DROP;
              port_discard_q <= 1'b1;
              stat_drop_q    <= sat_inc(stat_drop_q);
            end else begin
              state_q <= S_DATA;
              acc_q   <= '0;
              cnt_q   <= '0;
              len_q   <= '0;
              sof_q   <= 1'b1;
              bad_q   <= 1'b0;
            end
          end else if (bus.gmii_rxd != 8'h55) begin
            state_q      <= S_DROP;
            port_pream_q <= 1'b1;
          end
        end

        // A full word is held one extra cycle so that the following rxdv
        // tells whether it is the last word (eof) of the frame.
        S_DATA: begin
          if (bus.gmii_rxdv && (len_q == LEN_MAX)) begin
            // Overflow byte: close the frame as bad, drop the rest.
            crc_data_valid_q <= 1'b1;
            crc_data_q       <= mk_word(sof_q, 1'b1, cnt_q, acc_q);
            flag_pend_q      <= 1'b1;
            flag_good_q      <= 1'b0;
            sof_q            <= 1'b0;
            state_q          <= S_DROP;
          end else if (!bus.gmii_rxdv) begin
            if (cnt_q != '0) begin
              crc_data_valid_q <= 1'b1;
              crc_data_q       <= mk_word(sof_q, 1'b1, cnt_q, acc_q);
              flag_pend_q      <= 1'b1;
              flag_good_q      <= len_ok(len_q) && !bad_q;
            end
            sof_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == FULL) begin
            crc_data_valid_q <= 1'b1;
            crc_data_q       <= mk_word(sof_q, 1'b0, cnt_q, acc_q);
            sof_q            <= 1'b0;
            acc_q            <= {bus.gmii_rxd, {(DW-8){1'b0}}};
            cnt_q            <= CW'(1);
            len_q            <= len_q + LEN_W'(1);
            bad_q            <= bad_q | bus.gmii_rxer;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            len_q <= len_q + LEN_W'(1);
            bad_q <= bad_q | bus.gmii_rxer;
          end
        end

        S_DROP: begin
          if (!bus.gmii_rxdv) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.crc_data_valid  = crc_data_valid_q;
  assign bus.crc_data        = crc_data_q;
  assign bus.pkt_valid_wrreq = pkt_valid_wrreq_q;
  assign bus.pkt_valid       = pkt_valid_q;
  assign bus.port_receive    = port_receive_q;
  assign bus.port_discard    = port_discard_q;
  assign bus.port_pream      = port_pream_q;
  assign bus.stat_good       = stat_good_q;
  assign bus.stat_bad        = stat_bad_q;
  assign bus.stat_drop       = stat_drop_q;

endmodule
